// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: FU result packets and the CDB broadcast.
package cdb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int ROB_TAG_WIDTH = 5;
    localparam int NUM_FU        = 4;

    typedef struct packed {
        logic [XLEN-1:0]          v;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
        logic                     take_branch;
        logic                     done;
    } fu_out_packet_t;

    typedef struct packed {
        logic                     valid;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
        logic [XLEN-1:0]          v;
        logic                     take_branch;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any_grant
);

    // Scan offsets from farthest to nearest so the nearest requester is the last one written.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Selects one completed FU result per cycle, acks it combinationally and registers it onto the CDB.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU_P = NUM_FU,
    parameter int PW       = (NUM_FU_P > 1) ? $clog2(NUM_FU_P) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           squash,
    input  fu_out_packet_t fu_out_packet [NUM_FU_P],
    output logic [NUM_FU_P-1:0] ack,
    output cdb_packet_t    cdb_packet
);

    logic [NUM_FU_P-1:0] req;
    logic [NUM_FU_P-1:0] grant;
    logic [PW-1:0]       grant_idx;
    logic                any_grant;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       next_ptr;

    always_comb begin
        for (int i = 0; i < NUM_FU_P; i++) req[i] = fu_out_packet[i].done;
    end

    rr_arbiter #(.N(NUM_FU_P), .PW(PW)) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A squash drains every finished FU at once; nothing is broadcast for them.
    always_comb begin
        if (!reset)      ack = '0;
        else if (squash) ack = req;
        else             ack = grant;
    end

    assign next_ptr = (grant_idx == PW'(NUM_FU_P - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_packet <= '0;
            rr_ptr     <= '0;
        end else if (squash) begin
            cdb_packet.valid <= 1'b0;
            rr_ptr           <= '0;
        end else if (any_grant) begin
            cdb_packet.valid       <= 1'b1;
            cdb_packet.rob_tag     <= fu_out_packet[grant_idx].rob_tag;
            cdb_packet.v           <= fu_out_packet[grant_idx].v;
            cdb_packet.take_branch <= fu_out_packet[grant_idx].take_branch;
            rr_ptr                 <= next_ptr;
        end else begin
            cdb_packet.valid <= 1'b0;
        end
    end

endmodule
